sram_port_ctrl: RTL and testbench
=================================

Name: sram_port_ctrl

Overview:
- Initiator-side controller for the 64x32 single-port SRAM macro (pins CEB/WEB/A/D/Q, active-low enables, Q registered one cycle after a read).
- Converts a valid/ready request channel into macro pin activity and captures read data.
- Returns read data on a backpressured response channel through a 3-entry response FIFO.
- Optional post-reset zero-fill sweep. Sits between a cache/predictor table client and the macro instance.

Parameters:
- DEPTH, 64, macro word count
- ADDR_W, 6, address width (log2 DEPTH)
- DATA_W, 32, data width
- INIT_ZERO, 1, 1 = zero-fill all words after reset before accepting requests

Ports:
- clock  in  1  single clock, also drives macro CLK
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  read data available
- resp_ready  in  1  consumer takes read data
- resp_rdata  out  DATA_W  read data (FIFO head)
- init_done  out  1  zero-fill complete, controller operational
- sram_ceb  out  1  macro chip enable, active-low
- sram_web  out  1  macro write enable, active-low (0 = write)
- sram_a  out  ADDR_W  macro address
- sram_d  out  DATA_W  macro write data
- sram_q  in  DATA_W  macro read data

Behaviour:
- Reset (async, immediate):
  - state = INIT if INIT_ZERO else RUN; init counter = 0.
  - FIFO count and pointers = 0; rd_pending = 0.
  - Outputs: req_ready=0, resp_valid=0, resp_rdata=0, init_done=INIT_ZERO?0:1, sram_ceb=1, sram_web=1, sram_a=0, sram_d=0.
  - All macro pins are gated inactive by reset (ceb=1) for as long as reset is asserted.
- INIT state:
  - Each cycle drives ceb=0, web=0, a=counter, d=0; counter increments.
  - After the cycle with counter=DEPTH-1, go to RUN. init_done=1 from the next cycle onward.
  - req_ready=0 throughout INIT. The sweep takes exactly DEPTH cycles.
- RUN state:
  - req_ready = (count + rd_pending < 3). This depends only on registered state; there is no path from req_valid or resp_ready to req_ready. Writes are throttled by the same rule.
  - fire = req_valid && req_ready.
  - Macro pins are combinational from the request:
    - On fire: ceb=0, web=!req_write, a=req_addr, d = req_write ? req_wdata : 0.
    - Otherwise: ceb=1, web=1, a=0, d=0.
- Read path:
  - A read fire in cycle N sets rd_pending=1 in cycle N+1, when sram_q is valid.
  - At the end of N+1, sram_q is pushed into the FIFO; rd_pending clears unless another read fired in N+1.
  - resp_valid rises in cycle N+2 (2-cycle fire-to-response latency).
  - sram_q is sampled only when rd_pending=1; at all other times it is don't-care/garbage and ignored.
- Response FIFO:
  - 3 entries, in-order.
  - Pop when resp_valid && resp_ready. Push and pop in the same cycle leave count unchanged.
  - resp_rdata = head entry; 0 when empty.
  - Overflow is impossible by the req_ready rule; the bench asserts this.
- Ordering: a write to addr X in cycle N followed by a read of X in N+1 returns the new data (the macro writes at edge N).
- Throughput: one request per cycle sustained while resp_ready=1 (steady state count=1, pending=1). With resp_ready=0, at most 3 reads are outstanding, then req_ready=0.
- Reset mid-operation: pending reads and buffered responses are discarded and no response is ever issued for them. INIT restarts at address 0.

Test Plan:
- INIT_ZERO=1, release reset -> exactly 64 cycles of ceb=0/web=0, a=0..63, d=0; init_done=1 and req_ready=1 on cycle 64; then reads of addr 0, 31, 63 return 0x00000000.
- Write 0xDEADBEEF to addr 5, read addr 5 the next cycle -> resp_valid exactly 2 cycles after the read fire, resp_rdata=0xDEADBEEF.
- Back-to-back reads of addr 1..10 (preloaded 0x100+addr) with resp_ready=1 -> req_ready stays 1; responses 0x101..0x10A in order, one per cycle.
- resp_ready=0, issue 4 reads -> 3 accepted, req_ready=0 from the cycle count+pending reaches 3; raise resp_ready -> data drains in order, req_ready returns 1 and the 4th read is accepted.
- Assert reset with 2 responses buffered and 1 read pending -> sram_ceb=1 and resp_valid=0 immediately; after release, the INIT sweep restarts at addr 0 and no stale responses appear.
- Idle cycles with random sram_q values -> FIFO count unchanged, resp_valid stays 0.

Source files
------------

// File: rtl/sram_port_ctrl.sv
// rtl/sram_port_ctrl.sv - request/response controller for a 64x32 single-port SRAM macro
// Optional zero-fill sweep after reset; read data returned through a 3-entry response FIFO.
module sram_port_ctrl #(
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int INIT_ZERO = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_cnt, init_cnt_nxt;
  logic [1:0]        count, wptr, rptr;
  logic              rd_pending;
  logic              fire, push, pop;
  logic [DATA_W-1:0] fifo_mem [3];

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RST_STATE;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Reset gates every pin combinationally so the macro is idle while reset is held.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    req_ready    = 1'b0;
    fire         = 1'b0;
    sram_ceb     = 1'b1;
    sram_web     = 1'b1;
    sram_a       = '0;
    sram_d       = '0;
    if (!reset) begin
      case (state)
        ST_INIT: begin
          sram_ceb     = 1'b0;
          sram_web     = 1'b0;
          sram_a       = init_cnt;
          init_cnt_nxt = init_cnt + ADDR_W'(1);
          if (init_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
        end
        ST_RUN: begin
          // Outstanding reads (buffered + in flight) never exceed the FIFO depth.
          req_ready = (({1'b0, count} + {2'b00, rd_pending}) < 3'd3);
          fire      = req_valid && req_ready;
          if (fire) begin
            sram_ceb = 1'b0;
            sram_web = !req_write;
            sram_a   = req_addr;
            sram_d   = req_write ? req_wdata : '0;
          end
        end
        default: state_nxt = RST_STATE;
      endcase
    end
  end

  assign init_done  = (state == ST_RUN);
  assign push       = rd_pending;
  assign pop        = resp_valid && resp_ready;
  assign resp_valid = (count != 2'd0);
  assign resp_rdata = resp_valid ? fifo_mem[rptr] : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_pending <= 1'b0;
      count      <= 2'd0;
      wptr       <= 2'd0;
      rptr       <= 2'd0;
    end else begin
      rd_pending <= fire && !req_write;
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Macro Q is only meaningful the cycle after a read fire.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr] <= sram_q;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// tb/tb_sram_port_ctrl.sv - directed self-checking bench for sram_port_ctrl
module tb_sram_port_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        init_done, ceb, web;
  logic [5:0]  a;
  logic [31:0] d, q;
  logic [31:0] mem [64];
  int          total = 0;
  int          passed = 0;
  int          outst = 0;
  logic        ovf = 1'b0;

  always #5 clk = ~clk;

  sram_port_ctrl #(.DEPTH(64), .ADDR_W(6), .DATA_W(32), .INIT_ZERO(1)) dut (
    .clock(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_ceb(ceb), .sram_web(web), .sram_a(a), .sram_d(d), .sram_q(q)
  );

  // Macro model: Q registered after a read, garbage otherwise.
  always @(posedge clk) begin
    if (!ceb && !web) mem[a] <= d;
    if (!ceb && web) q <= mem[a];
    else             q <= $urandom;
  end

  // Outstanding reads must never exceed the 3-entry FIFO.
  always @(negedge clk) begin
    if (rst) outst = 0;
    else begin
      if (req_valid && req_ready && !req_write) outst++;
      if (resp_valid && resp_ready) outst--;
      if (outst > 3) ovf = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic req(input logic v, input logic w, input logic [5:0] ad, input logic [31:0] wd);
    req_valid = v; req_write = w; req_addr = ad; req_wdata = wd;
  endtask

  task automatic check_sweep();
    for (int i = 0; i < 64; i++) begin
      settle();
      chk("sweep_ceb", ceb, 0);
      chk("sweep_web", web, 0);
      chk("sweep_a", a, 32'(i));
      chk("sweep_d", d, 0);
      chk("sweep_req_ready", req_ready, 0);
      chk("sweep_init_done", init_done, 0);
      chk("sweep_resp_valid", resp_valid, 0);
      next();
    end
    settle();
    chk("post_sweep_init_done", init_done, 1);
    chk("post_sweep_req_ready", req_ready, 1);
    chk("post_sweep_ceb", ceb, 1);
  endtask

  initial begin
    rst = 1'b1; resp_ready = 1'b0;
    req(0, 0, 0, 0);
    repeat (2) next();
    settle();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_ceb", ceb, 1);
    chk("rst_web", web, 1);
    chk("rst_a", a, 0);
    chk("rst_d", d, 0);
    next();
    rst = 1'b0;
    check_sweep();

    // Zero-filled reads of 0, 31, 63
    resp_ready = 1'b1;
    req(1, 0, 0, 0);
    settle();
    chk("rd0_ceb", ceb, 0); chk("rd0_web", web, 1); chk("rd0_a", a, 0);
    next(); req(1, 0, 31, 0);
    settle(); chk("rd0_latency", resp_valid, 0); chk("rd31_a", a, 31);
    next(); req(1, 0, 63, 0);
    settle(); chk("rd0_valid", resp_valid, 1); chk("rd0_data", resp_rdata, 0);
    next(); req(0, 0, 0, 0);
    settle(); chk("rd31_valid", resp_valid, 1); chk("rd31_data", resp_rdata, 0);
    next();
    settle(); chk("rd63_valid", resp_valid, 1); chk("rd63_data", resp_rdata, 0);
    next();
    settle(); chk("rd_zero_drained", resp_valid, 0);

    // Write then read same address next cycle
    req(1, 1, 5, 32'hDEADBEEF);
    settle();
    chk("wr5_ceb", ceb, 0); chk("wr5_web", web, 0); chk("wr5_a", a, 5); chk("wr5_d", d, 32'hDEADBEEF);
    next(); req(1, 0, 5, 32'h12345678);
    settle(); chk("rd5_web", web, 1); chk("rd5_d", d, 0);
    next(); req(0, 0, 0, 0);
    settle(); chk("rd5_n1", resp_valid, 0);
    next();
    settle(); chk("rd5_n2_valid", resp_valid, 1); chk("rd5_data", resp_rdata, 32'hDEADBEEF);
    next();
    settle(); chk("rd5_drained", resp_valid, 0);

    // Preload 1..10 then stream reads
    for (int i = 1; i <= 10; i++) begin
      req(1, 1, 6'(i), 32'h100 + 32'(i));
      settle(); chk("preload_ready", req_ready, 1);
      next();
    end
    for (int i = 0; i < 12; i++) begin
      if (i < 10) req(1, 0, 6'(i + 1), 0);
      else        req(0, 0, 0, 0);
      settle();
      if (i < 10) chk("stream_req_ready", req_ready, 1);
      if (i >= 2) begin
        chk("stream_valid", resp_valid, 1);
        chk("stream_data", resp_rdata, 32'h100 + 32'(i - 1));
      end
      next();
    end
    settle(); chk("stream_drained", resp_valid, 0);

    // Backpressure: 4 reads, only 3 accepted until drain
    resp_ready = 1'b0;
    req(1, 0, 1, 0); settle(); chk("bp_rdy0", req_ready, 1); next();
    req(1, 0, 2, 0); settle(); chk("bp_rdy1", req_ready, 1); next();
    req(1, 0, 3, 0); settle(); chk("bp_rdy2", req_ready, 1); next();
    req(1, 0, 4, 0); settle();
    chk("bp_rdy3", req_ready, 0); chk("bp_ceb3", ceb, 1);
    chk("bp_head3", resp_rdata, 32'h101);
    next(); settle(); chk("bp_rdy4", req_ready, 0); chk("bp_head4", resp_rdata, 32'h101);
    next(); resp_ready = 1'b1;
    settle(); chk("bp_rdy5", req_ready, 0); chk("bp_head5", resp_rdata, 32'h101);
    next(); settle();
    chk("bp_rdy6", req_ready, 1); chk("bp_ceb6", ceb, 0); chk("bp_a6", a, 4);
    chk("bp_head6", resp_rdata, 32'h102);
    next(); req(0, 0, 0, 0);
    settle(); chk("bp_head7", resp_rdata, 32'h103);
    next(); settle(); chk("bp_head8", resp_rdata, 32'h104); chk("bp_valid8", resp_valid, 1);
    next(); settle(); chk("bp_drained", resp_valid, 0);

    // Idle with one buffered response and random sram_q
    resp_ready = 1'b0;
    req(1, 0, 10, 0); next(); req(0, 0, 0, 0); next();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("idle_valid", resp_valid, 1);
      chk("idle_data", resp_rdata, 32'h10A);
      chk("idle_ceb", ceb, 1);
      next();
    end
    resp_ready = 1'b1;
    next(); settle(); chk("idle_drained", resp_valid, 0);

    // Reset with 2 buffered and 1 pending
    resp_ready = 1'b0;
    req(1, 0, 1, 0); next();
    req(1, 0, 2, 0); next();
    req(1, 0, 3, 0); next();
    req(0, 0, 0, 0);
    settle(); chk("pre_rst_valid", resp_valid, 1);
    rst = 1'b1; #1;
    chk("mid_rst_ceb", ceb, 1);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_init_done", init_done, 0);
    next(); next();
    rst = 1'b0;
    check_sweep();
    resp_ready = 1'b1;
    next(); settle(); chk("no_stale_a", resp_valid, 0);
    req(1, 0, 7, 0); next(); req(0, 0, 0, 0);
    settle(); chk("no_stale_b", resp_valid, 0);
    next(); settle();
    chk("fresh_valid", resp_valid, 1); chk("fresh_data", resp_rdata, 0);
    next(); settle(); chk("fresh_drained", resp_valid, 0);

    chk("no_overflow", ovf, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
